// File: rtl/ntt_stage_sequencer_if.sv
// Handshake and memory-address bundle between the NTT stage sequencer and its datapath.
// The hold input exists only when NTT_SEQ_HOLD_EN is defined.
interface ntt_stage_sequencer_if #(
  parameter int LOG_N = 10
);
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-1:0] tw_addr;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;
`ifdef NTT_SEQ_HOLD_EN
  logic             hold;
`endif

  modport master (
`ifdef NTT_SEQ_HOLD_EN
    input  hold,
`endif
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
`ifdef NTT_SEQ_HOLD_EN
    output hold,
`endif
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Address/control sequencer for an in-place Cooley-Tukey forward NTT, with a delayed write-back path.
// Optional issue stall input enabled by defining NTT_SEQ_HOLD_EN.
module ntt_stage_sequencer #(
  parameter int LOG_N      = 10,
  parameter int PIPE_DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  ntt_stage_sequencer_if.master bus
);

  localparam int SW = $clog2(LOG_N + 1);
  localparam int CW = $clog2(PIPE_DEPTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [LOG_N-1:0] HALF   = LOG_N'(1) << (LOG_N - 1);
  localparam logic [LOG_N-1:0] K_LAST = HALF - LOG_N'(1);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
  localparam logic [CW-1:0]    D_LAST = CW'(PIPE_DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [LOG_N-1:0] k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG_N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [LOG_N-1:0] tw_addr_q, tw_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;
  logic [LOG_N-1:0] wr_addr_a_q, wr_addr_a_d;
  logic [LOG_N-1:0] wr_addr_b_q, wr_addr_b_d;
  logic             tail_v;
  logic [LOG_N-1:0] tail_a, tail_b;
  logic [LOG_N-1:0] t_v, i_v, jj_v, base_v, a_v;
  logic             hold_in;

`ifdef NTT_SEQ_HOLD_EN
  assign hold_in = bus.hold;
`else
  assign hold_in = 1'b0;
`endif

  // In RUN, k_q is the butterfly just issued when rd_en_q is set, otherwise the one still pending.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (rd_en_q) begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            k_d     = '0;
            cnt_d   = '0;
          end else begin
            k_d = k_q + LOG_N'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == D_LAST) begin
          cnt_d = '0;
          if (s_q == S_LAST) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            s_d     = s_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses for the butterfly issued next cycle; 2t = N >> s and i*2t is a left shift.
  always_comb begin
    t_v     = HALF >> s_d;
    i_v     = k_d >> (S_LAST - s_d);
    jj_v    = k_d & (t_v - LOG_N'(1));
    base_v  = i_v << (SW'(LOG_N) - s_d);
    a_v     = base_v | jj_v;
    rd_en_d = (state_d == RUN) && !(hold_in && (state_q == RUN));
    rd_addr_a_d = rd_en_d ? a_v                         : rd_addr_a_q;
    rd_addr_b_d = rd_en_d ? a_v + t_v                   : rd_addr_b_q;
    tw_addr_d   = rd_en_d ? (LOG_N'(1) << s_d) + i_v    : tw_addr_q;
    busy_d      = (state_d == RUN) || (state_d == DRAIN);
    done_d      = (state_d == FIN);
    wr_en_d     = tail_v;
    wr_addr_a_d = tail_v ? tail_a : wr_addr_a_q;
    wr_addr_b_d = tail_v ? tail_b : wr_addr_b_q;
  end

  generate
    if (PIPE_DEPTH == 1) begin : g_direct
      assign tail_v = rd_en_q;
      assign tail_a = rd_addr_a_q;
      assign tail_b = rd_addr_b_q;
    end else begin : g_pipe
      logic [PIPE_DEPTH-2:0] pv_q, pv_d;
      logic [LOG_N-1:0]      pa_q [PIPE_DEPTH-1];
      logic [LOG_N-1:0]      pa_d [PIPE_DEPTH-1];
      logic [LOG_N-1:0]      pb_q [PIPE_DEPTH-1];
      logic [LOG_N-1:0]      pb_d [PIPE_DEPTH-1];

      always_comb begin
        pv_d    = {pv_q[PIPE_DEPTH-2:0], rd_en_q} >> 0;
        pa_d[0] = rd_addr_a_q;
        pb_d[0] = rd_addr_b_q;
        for (int j = 1; j < PIPE_DEPTH - 1; j++) begin
          pa_d[j] = pa_q[j-1];
          pb_d[j] = pb_q[j-1];
        end
      end

      // Valid bits are cleared on reset so in-flight butterflies never write back.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pv_q <= '0;
          for (int j = 0; j < PIPE_DEPTH - 1; j++) begin
            pa_q[j] <= '0;
            pb_q[j] <= '0;
          end
        end else begin
          pv_q <= pv_d;
          for (int j = 0; j < PIPE_DEPTH - 1; j++) begin
            pa_q[j] <= pa_d[j];
            pb_q[j] <= pb_d[j];
          end
        end
      end

      assign tail_v = pv_q[PIPE_DEPTH-2];
      assign tail_a = pa_q[PIPE_DEPTH-2];
      assign tail_b = pb_q[PIPE_DEPTH-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_a_q <= wr_addr_a_d;
      wr_addr_b_q <= wr_addr_b_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr_a = wr_addr_a_q;
  assign bus.wr_addr_b = wr_addr_b_q;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: a small (LOG_N=3, PIPE_DEPTH=2) and a default-size instance
// checked cycle by cycle against an arithmetic model of the transform schedule.
module tb_ntt_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n3, rst_n10;

  ntt_stage_sequencer_if #(.LOG_N(3))  b3();
  ntt_stage_sequencer_if #(.LOG_N(10)) b10();

  ntt_stage_sequencer #(.LOG_N(3), .PIPE_DEPTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n3), .bus(b3)
  );
  ntt_stage_sequencer #(.LOG_N(10), .PIPE_DEPTH(8)) dut10 (
    .clk(clk), .rst_n(rst_n10), .bus(b10)
  );

  typedef struct {
    int a;
    int b;
    int tw;
  } issue_t;

  int     total = 0;
  int     bad   = 0;
  issue_t plan[12];
  issue_t obs3[$];
  int     last_v[2][5];

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Butterfly issued rel cycles after start was sampled, straight from the stage/index formulas.
  function automatic void issue_at(input int logn, input int p, input int rel,
                                   output bit v, output int a, output int b, output int tw);
    int half, per, x, s, k, t, i, jj;
    half = 1 << (logn - 1);
    per  = half + p;
    v = 1'b0; a = 0; b = 0; tw = 0;
    if (rel >= 1 && rel <= logn * per) begin
      x = rel - 1;
      s = x / per;
      k = x % per;
      if (k < half) begin
        t  = (1 << logn) >> (s + 1);
        i  = k / t;
        jj = k % t;
        a  = i * 2 * t + jj;
        b  = a + t;
        tw = (1 << s) + i;
        v  = 1'b1;
      end
    end
  endfunction

  function automatic void model(input int logn, input int p, input int rel,
                                output bit rd, output int a, output int b, output int tw,
                                output bit wr, output int wa, output int wb,
                                output bit busy, output bit done);
    int tot, unused_tw;
    tot = logn * ((1 << (logn - 1)) + p);
    issue_at(logn, p, rel, rd, a, b, tw);
    issue_at(logn, p, rel - p, wr, wa, wb, unused_tw);
    busy = (rel >= 1) && (rel <= tot);
    done = (rel == tot + 1);
  endfunction

  task automatic clear_last(input int id);
    for (int j = 0; j < 5; j++) last_v[id][j] = 0;
  endtask

  task automatic check_cycle(input int id, input int rel, input string tag);
    bit e_rd, e_wr, e_busy, e_done;
    int ea, eb, et, ewa, ewb;
    int g[9];
    if (id == 0) model(3, 2, rel, e_rd, ea, eb, et, e_wr, ewa, ewb, e_busy, e_done);
    else         model(10, 8, rel, e_rd, ea, eb, et, e_wr, ewa, ewb, e_busy, e_done);
    if (e_rd) begin last_v[id][0] = ea; last_v[id][1] = eb; last_v[id][2] = et; end
    if (e_wr) begin last_v[id][3] = ewa; last_v[id][4] = ewb; end
    if (id == 0) begin
      g[0] = int'(b3.rd_en);  g[1] = int'(b3.rd_addr_a); g[2] = int'(b3.rd_addr_b);
      g[3] = int'(b3.tw_addr); g[4] = int'(b3.wr_en);    g[5] = int'(b3.wr_addr_a);
      g[6] = int'(b3.wr_addr_b); g[7] = int'(b3.busy);   g[8] = int'(b3.done);
    end else begin
      g[0] = int'(b10.rd_en);  g[1] = int'(b10.rd_addr_a); g[2] = int'(b10.rd_addr_b);
      g[3] = int'(b10.tw_addr); g[4] = int'(b10.wr_en);    g[5] = int'(b10.wr_addr_a);
      g[6] = int'(b10.wr_addr_b); g[7] = int'(b10.busy);   g[8] = int'(b10.done);
    end
    checkOutput($sformatf("%s.rd_en@%0d", tag, rel),     g[0], int'(e_rd));
    checkOutput($sformatf("%s.rd_addr_a@%0d", tag, rel), g[1], last_v[id][0]);
    checkOutput($sformatf("%s.rd_addr_b@%0d", tag, rel), g[2], last_v[id][1]);
    checkOutput($sformatf("%s.tw_addr@%0d", tag, rel),   g[3], last_v[id][2]);
    checkOutput($sformatf("%s.wr_en@%0d", tag, rel),     g[4], int'(e_wr));
    checkOutput($sformatf("%s.wr_addr_a@%0d", tag, rel), g[5], last_v[id][3]);
    checkOutput($sformatf("%s.wr_addr_b@%0d", tag, rel), g[6], last_v[id][4]);
    checkOutput($sformatf("%s.busy@%0d", tag, rel),      g[7], int'(e_busy));
    checkOutput($sformatf("%s.done@%0d", tag, rel),      g[8], int'(e_done));
  endtask

  task automatic applyStimulus(input bit st);
    b3.start = st;
    @(negedge clk);
  endtask

  task automatic check_plan(input string tag);
    checkOutput({tag, ".issue_count"}, obs3.size(), 12);
    for (int j = 0; j < 12 && j < obs3.size(); j++) begin
      checkOutput($sformatf("%s.a[%0d]", tag, j),  obs3[j].a,  plan[j].a);
      checkOutput($sformatf("%s.b[%0d]", tag, j),  obs3[j].b,  plan[j].b);
      checkOutput($sformatf("%s.tw[%0d]", tag, j), obs3[j].tw, plan[j].tw);
    end
  endtask

  always @(negedge clk) begin
    issue_t e;
    if (b3.rd_en) begin
      e.a  = int'(b3.rd_addr_a);
      e.b  = int'(b3.rd_addr_b);
      e.tw = int'(b3.tw_addr);
      obs3.push_back(e);
    end
  end

  initial begin
    int gap, rd_cnt, wr_cnt, rd5, wr4, done_at, big_rd, big_wr, big_done;
    issue_t big_last;

    plan = '{'{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1},
             '{0,2,2}, '{1,3,2}, '{4,6,3}, '{5,7,3},
             '{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}};
    b3.start  = 1'b0;
    b10.start = 1'b0;
`ifdef NTT_SEQ_HOLD_EN
    b3.hold  = 1'b0;
    b10.hold = 1'b0;
`endif
    rst_n3  = 1'b0;
    rst_n10 = 1'b0;
    clear_last(0);
    clear_last(1);
    repeat (3) @(negedge clk);
    check_cycle(0, -1, "reset");
    check_cycle(1, -1, "reset");
    rst_n3  = 1'b1;
    rst_n10 = 1'b1;
    @(negedge clk);

    // Run A: random idle gap, random ignored start pulses, plus one in RUN and one in the done cycle.
    gap = $urandom_range(0, 4);
    for (int g = 0; g < gap; g++) begin
      check_cycle(0, -1, "A.idle");
      applyStimulus(1'b0);
    end
    obs3.delete();
    check_cycle(0, 0, "A");
    applyStimulus(1'b1);
    for (int rel = 1; rel <= 22; rel++) begin
      check_cycle(0, rel, "A");
      if (rel == 5 || rel == 19)  applyStimulus(1'b1);
      else if (rel < 19)          applyStimulus($urandom_range(0, 2) == 0);
      else                        applyStimulus(1'b0);
    end
    check_plan("A");

    // Run B: start held high restarts right after IDLE; stage hand-off latency measured.
    rd_cnt = 0; wr_cnt = 0; rd5 = -1; wr4 = -1; done_at = -1;
    check_cycle(0, 0, "B");
    applyStimulus(1'b1);
    for (int rel = 1; rel <= 42; rel++) begin
      check_cycle(0, (rel >= 20) ? rel - 20 : rel, "B");
      if (rel < 20) begin
        if (b3.rd_en) begin rd_cnt++; if (rd_cnt == 5) rd5 = rel; end
        if (b3.wr_en) begin wr_cnt++; if (wr_cnt == 4) wr4 = rel; end
        if (b3.done && done_at < 0) done_at = rel;
      end
      applyStimulus(rel <= 20);
    end
    checkOutput("B.wr_pulses", wr_cnt, 12);
    checkOutput("B.done_cycle", done_at, 19);
    checkOutput("B.stage_handoff", rd5 - wr4, 1);

    // Run C: reset at the third stage-1 issue, then a clean replay.
    for (int rel = 0; rel <= 9; rel++) begin
      check_cycle(0, rel, "C");
      if (rel == 9) rst_n3 = 1'b0;
      applyStimulus(rel == 0);
    end
    clear_last(0);
    check_cycle(0, -1, "C.rst");
    rst_n3 = 1'b1;
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b0);
      check_cycle(0, -1, "C.after");
    end
    applyStimulus(1'b0);
    obs3.delete();
    check_cycle(0, 0, "C2");
    applyStimulus(1'b1);
    for (int rel = 1; rel <= 21; rel++) begin
      check_cycle(0, rel, "C2");
      applyStimulus(1'b0);
    end
    check_plan("C2");

`ifdef NTT_SEQ_HOLD_EN
    // Run H: issue stalled for three cycles after the second issue.
    obs3.delete();
    done_at = -1;
    applyStimulus(1'b1);
    for (int rel = 1; rel <= 26; rel++) begin
      if (b3.done && done_at < 0) done_at = rel;
      b3.hold = (rel >= 2 && rel <= 4);
      applyStimulus(1'b0);
    end
    b3.hold = 1'b0;
    check_plan("H");
    checkOutput("H.done_cycle", done_at, 22);
`endif

    // Run D: default size, full model comparison.
    big_rd = 0; big_wr = 0; big_done = -1;
    big_last = '{0, 0, 0};
    b10.start = 1'b1;
    @(negedge clk);
    b10.start = 1'b0;
    for (int rel = 1; rel <= 5205; rel++) begin
      check_cycle(1, rel, "D");
      if (b10.rd_en) begin
        big_rd++;
        big_last.a  = int'(b10.rd_addr_a);
        big_last.b  = int'(b10.rd_addr_b);
        big_last.tw = int'(b10.tw_addr);
      end
      if (b10.wr_en) big_wr++;
      if (b10.done && big_done < 0) big_done = rel;
      @(negedge clk);
    end
    checkOutput("D.rd_pulses", big_rd, 5120);
    checkOutput("D.wr_pulses", big_wr, 5120);
    checkOutput("D.done_cycle", big_done, 5201);
    checkOutput("D.last_a", big_last.a, 1022);
    checkOutput("D.last_b", big_last.b, 1023);
    checkOutput("D.last_tw", big_last.tw, 1023);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
